// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: BPC bits per clock through a ripple slice,
// with the inter-slice carry held in a register and a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / BPC;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb, sum_r;
  logic             c, cout_r, ovf_r;
  logic [CNT_W-1:0] cnt;
  logic             accept, last;
  int               base;
  logic [BPC-1:0]   sa, sb, ss;
  logic [BPC:0]     rc;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (cnt == CNT_W'(STEPS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Ripple slice: full adders over the current BPC bits, seeded by the carry register
  always_comb begin
    base  = int'(cnt) * BPC;
    sa    = BPC'(opa >> base);
    sb    = BPC'(opb >> base);
    ss    = '0;
    rc    = '0;
    rc[0] = c;
    for (int i = 0; i < BPC; i++) begin
      ss[i]   = sa[i] ^ sb[i] ^ rc[i];
      rc[i+1] = (sa[i] & sb[i]) | (rc[i] & (sa[i] ^ sb[i]));
    end
  end

  // Subtraction is a + ~b + ~cin, so the borrow-in becomes an inverted carry seed
  always_ff @(posedge clk) begin
    if (rst) begin
      opa    <= '0;
      opb    <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      opa   <= a;
      opb   <= sub ? ~b : b;
      c     <= cin ^ sub;
      cnt   <= '0;
      sum_r <= '0;
    end else if (state == RUN) begin
      sum_r <= sum_r | (WIDTH'(ss) << base);
      c     <= rc[BPC];
      cnt   <= cnt + CNT_W'(1);
      if (last) begin
        cout_r <= rc[BPC];
        ovf_r  <= rc[BPC-1] ^ rc[BPC];
      end
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8-bit instances (BPC 1 and 4) plus a
// 4-bit exhaustive sweep over BPC 1, 2 and 4 against reference arithmetic.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       st1, st4, cin8, sub8;
  logic [7:0] a8, b8;
  logic       busy81, done81, cout81, ovf81;
  logic       busy84, done84, cout84, ovf84;
  logic [7:0] sum81, sum84;

  logic       stw4, cin4, sub4;
  logic [3:0] a4, b4;
  logic       busy41, done41, cout41, ovf41;
  logic       busy42, done42, cout42, ovf42;
  logic       busy44, done44, cout44, ovf44;
  logic [3:0] sum41, sum42, sum44;

  int checks = 0;
  int passes = 0;

  serial_adder #(.WIDTH(8), .BPC(1)) u81 (.clk(clk), .rst(rst), .start(st1), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .busy(busy81), .done(done81), .sum(sum81), .cout(cout81), .ovf(ovf81));
  serial_adder #(.WIDTH(8), .BPC(4)) u84 (.clk(clk), .rst(rst), .start(st4), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .busy(busy84), .done(done84), .sum(sum84), .cout(cout84), .ovf(ovf84));
  serial_adder #(.WIDTH(4), .BPC(1)) u41 (.clk(clk), .rst(rst), .start(stw4), .a(a4), .b(b4),
    .cin(cin4), .sub(sub4), .busy(busy41), .done(done41), .sum(sum41), .cout(cout41), .ovf(ovf41));
  serial_adder #(.WIDTH(4), .BPC(2)) u42 (.clk(clk), .rst(rst), .start(stw4), .a(a4), .b(b4),
    .cin(cin4), .sub(sub4), .busy(busy42), .done(done42), .sum(sum42), .cout(cout42), .ovf(ovf42));
  serial_adder #(.WIDTH(4), .BPC(4)) u44 (.clk(clk), .rst(rst), .start(stw4), .a(a4), .b(b4),
    .cin(cin4), .sub(sub4), .busy(busy44), .done(done44), .sum(sum44), .cout(cout44), .ovf(ovf44));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One operation on the 8-bit instances; junk_at > 0 pulses start with other
  // operands at that sample while the operation is still in flight.
  task automatic run8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                      input logic icin, input logic isub, input logic [7:0] es,
                      input logic ec, input logic eo, input bit both, input int junk_at);
    int nb1 = 0, nd1 = 0, dc1 = 0, nb4 = 0, nd4 = 0, dc4 = 0, ovl = 0;
    logic [9:0] r1 = '0, r4 = '0;
    a8 = ia; b8 = ib; cin8 = icin; sub8 = isub;
    st1 = 1'b1; st4 = both;
    tick();
    st1 = 1'b0; st4 = 1'b0;
    for (int s = 1; s <= 12; s++) begin
      if (busy81) nb1++;
      if (done81) begin nd1++; dc1 = s; r1 = {sum81, cout81, ovf81}; end
      if (busy84) nb4++;
      if (done84) begin nd4++; dc4 = s; r4 = {sum84, cout84, ovf84}; end
      if ((busy81 && done81) || (busy84 && done84)) ovl++;
      if (s == junk_at) begin
        a8 = 8'h55; b8 = 8'h33; cin8 = 1'b1; sub8 = ~isub;
        st1 = 1'b1; st4 = both;
      end else begin
        st1 = 1'b0; st4 = 1'b0;
      end
      tick();
    end
    st1 = 1'b0; st4 = 1'b0;
    chk($sformatf("%s busy_cycles_bpc1", tag), nb1, 8);
    chk($sformatf("%s done_cycle_bpc1", tag), dc1, 9);
    chk($sformatf("%s done_pulses_bpc1", tag), nd1, 1);
    chk($sformatf("%s result_bpc1", tag), r1, {es, ec, eo});
    chk($sformatf("%s busy_done_overlap", tag), ovl, 0);
    if (both) begin
      chk($sformatf("%s busy_cycles_bpc4", tag), nb4, 2);
      chk($sformatf("%s done_cycle_bpc4", tag), dc4, 3);
      chk($sformatf("%s done_pulses_bpc4", tag), nd4, 1);
      chk($sformatf("%s result_bpc4", tag), r4, {es, ec, eo});
    end
  endtask

  initial begin
    int sawd, ovl4;
    logic [5:0] r41, r42, r44, e4;
    int full, sa, sb, rs;

    rst = 1'b1; st1 = 0; st4 = 0; stw4 = 0;
    a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0;
    tick(); tick();
    chk("reset busy/done", {busy81, done81, busy84, done84, busy41, done41}, 6'b0);
    chk("reset sum/cout/ovf", {sum81, cout81, ovf81, sum84, cout84, ovf84}, 20'h0);
    rst = 1'b0;
    tick();

    run8("add_100_27",    8'd100, 8'd27,  1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1, 0);
    run8("add_127_0_c1",  8'd127, 8'd0,   1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1, 0);
    run8("add_200_100",   8'd200, 8'd100, 1'b0, 1'b0, 8'h2C, 1'b1, 1'b0, 1'b1, 0);
    run8("sub_5_7",       8'd5,   8'd7,   1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1, 0);
    run8("sub_80_1",      8'h80,  8'h01,  1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1, 0);
    run8("sub_10_3_b1",   8'd10,  8'd3,   1'b1, 1'b1, 8'h06, 1'b1, 1'b0, 1'b1, 0);
    run8("add_ff_01",     8'hFF,  8'h01,  1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0);
    run8("add_ff_ff_c1",  8'hFF,  8'hFF,  1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 0);
    run8("start_mid_run", 8'd100, 8'd27,  1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1, 1);

    // start held through DONE re-arms immediately
    a8 = 8'd100; b8 = 8'd27; cin8 = 0; sub8 = 0; st1 = 1'b1;
    tick();
    st1 = 1'b0;
    repeat (8) tick();
    chk("rearm first done", {done81, sum81}, {1'b1, 8'h7F});
    a8 = 8'd200; b8 = 8'd100; st1 = 1'b1;
    tick();
    st1 = 1'b0;
    chk("rearm busy/done", {busy81, done81}, 2'b10);
    repeat (8) tick();
    chk("rearm second result", {done81, sum81, cout81, ovf81}, {1'b1, 8'h2C, 1'b1, 1'b0});
    tick(); tick();
    chk("hold after done", {done81, busy81, sum81, cout81, ovf81}, {2'b00, 8'h2C, 1'b1, 1'b0});

    // reset on the 4th RUN cycle discards the operation
    a8 = 8'h07; b8 = 8'h00; st1 = 1'b1;
    tick();
    st1 = 1'b0;
    tick(); tick(); tick();
    chk("busy before rst", busy81, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid rst outputs", {busy81, done81, sum81, cout81, ovf81}, 12'h0);
    sawd = 0;
    for (int s = 0; s < 12; s++) begin
      if (done81 || busy81) sawd++;
      tick();
    end
    chk("no done after rst", sawd, 0);
    run8("after_rst", 8'h05, 8'h07, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b0, 1'b0, 0);

    // exhaustive 4-bit sweep
    ovl4 = 0;
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          for (int is = 0; is < 2; is++) begin
            a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); sub4 = 1'(is); stw4 = 1'b1;
            tick();
            stw4 = 1'b0;
            r41 = '0; r42 = '0; r44 = '0;
            for (int s = 1; s <= 6; s++) begin
              if (done41) r41 = {1'b1, sum41, cout41, ovf41};
              if (done42) r42 = {1'b1, sum42, cout42, ovf42};
              if (done44) r44 = {1'b1, sum44, cout44, ovf44};
              if ((busy41 && done41) || (busy42 && done42) || (busy44 && done44)) ovl4++;
              tick();
            end
            sa = (ia >= 8) ? ia - 16 : ia;
            sb = (ib >= 8) ? ib - 16 : ib;
            if (is == 0) begin
              full = ia + ib + ic;
              rs = sa + sb + ic;
              e4 = {1'b1, 4'(full), full > 15, (rs > 7 || rs < -8)};
            end else begin
              full = ia - ib - ic;
              rs = sa - sb - ic;
              e4 = {1'b1, 4'(full), ia >= ib + ic, (rs > 7 || rs < -8)};
            end
            chk($sformatf("w4 bpc1 a=%0d b=%0d cin=%0d sub=%0d", ia, ib, ic, is), r41, e4);
            chk($sformatf("w4 bpc2 a=%0d b=%0d cin=%0d sub=%0d", ia, ib, ic, is), r42, e4);
            chk($sformatf("w4 bpc4 a=%0d b=%0d cin=%0d sub=%0d", ia, ib, ic, is), r44, e4);
          end
    chk("w4 busy_done_overlap", ovl4, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
